// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared types and helpers for the round-robin mux arbiter.
//   - state_t       : controller state (IDLE / GRANT), 1 bit
//   - sel_width(n)  : select width for n requesters, never below 1
//   - next_idx(i,n) : modulo-n increment without a divider
package mux_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans req starting at ptr and
//   wrapping modulo N; the first set bit wins.
//   Ports:
//     req  [N]  : request vector
//     ptr  [SW] : highest-priority index (always < N)
//     pick [SW] : winning index (0 when nothing is requested)
//     any       : at least one request present
module rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] pick,
    output logic          any
);

    logic [SW-1:0] cand [N];
    logic [N-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            // ptr + gi can reach 2N-2; one extra bit holds it, and a single
            // conditional subtract brings it back into 0..N-1.
            logic [SW:0] sum;
            assign sum       = {1'b0, ptr} + (SW+1)'(gi);
            assign cand[gi]  = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : sum[SW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Walk offsets from the far end so the smallest offset is written last
    // and therefore wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick = cand[i];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter sharing one N:1 mux between N valid/ready
//   requesters and a single consumer.
//   Ports:
//     CLK, RST      : clock (rising edge), asynchronous active-high reset
//     I     [N*W]   : requester data, requester k at [k*W +: W]
//     VALID [N]     : per-requester valid
//     READY [N]     : per-requester accept, only the granted bit can be high
//     Y     [W]     : muxed data to the consumer
//     Y_VALID       : consumer valid
//     Y_READY       : consumer ready
//     LAST  [N]     : end-of-packet marker (only with MUX_RR_ARBITER_LOCK_EN)
//     S     [SW]    : registered grant index
//     BUSY          : high while a grant is held
//   Build option MUX_RR_ARBITER_LOCK_EN: the grant is only released on a
//   transfer with LAST[sel] set, so multi-beat packets are never interleaved.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    parameter  int W  = 1,
    localparam int SW = sel_width(N)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N*W-1:0] I,
    input  logic [N-1:0]   VALID,
    output logic [N-1:0]   READY,
    output logic [W-1:0]   Y,
    output logic           Y_VALID,
    input  logic           Y_READY,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic [N-1:0]   LAST,
`endif
    output logic [SW-1:0]  S,
    output logic           BUSY
);

    state_t        state_reg, state_next;
    logic [SW-1:0] sel_reg, sel_next;
    logic [SW-1:0] ptr_reg, ptr_next;

    logic [N-1:0]  sel_onehot;
    logic [N-1:0]  other_req;
    logic [N-1:0]  pick_req;
    logic [SW-1:0] pick_ptr;
    logic [SW-1:0] pick;
    logic          pick_any;
    logic [SW-1:0] ptr_after;
    logic [W-1:0]  data_sel;
    logic          valid_sel;
    logic          last_sel;
    logic          xfer;
    logic          release_grant;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_reg == SW'(gi));
        end
    endgenerate

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_onehot[k]) begin
                data_sel = I[k*W +: W];
            end
        end
    end

    assign valid_sel = |(VALID & sel_onehot);
    assign xfer      = (state_reg == GRANT) && valid_sel && Y_READY;

`ifdef MUX_RR_ARBITER_LOCK_EN
    assign last_sel  = |(LAST & sel_onehot);
`else
    assign last_sel  = 1'b1;
`endif

    assign release_grant = xfer && last_sel;
    assign ptr_after     = SW'(next_idx(int'(sel_reg), N));

    // While granted, the picker already looks at the post-transfer pointer
    // with the current owner masked out, so a release can hand over in the
    // same edge. A sole requester is not masked and simply keeps the grant.
    assign other_req = VALID & ~sel_onehot;
    assign pick_req  = (state_reg == GRANT) ? ((other_req != '0) ? other_req : VALID) : VALID;
    assign pick_ptr  = (state_reg == GRANT) ? ptr_after : ptr_reg;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (pick_any)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    sel_next   = pick;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_next = ptr_after;
                    if (pick_any) begin
                        sel_next = pick;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        S       = sel_reg;
        Y       = '0;
        Y_VALID = 1'b0;
        READY   = '0;
        BUSY    = 1'b0;
        if (state_reg == GRANT) begin
            Y       = data_sel;
            Y_VALID = valid_sel;
            READY   = sel_onehot & {N{Y_READY}};
            BUSY    = 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Self-checking bench: dut_a (N=2, W=1) and dut_b (N=3, W=4) share a clock.
//   Directed scenarios use literal expectations; the random scenario compares
//   against a behavioural model of the round-robin rules.
module tb_mux_rr_arbiter;

`ifdef MUX_RR_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic [1:0]  a_i, a_valid, a_ready, a_last;
    logic [0:0]  a_y, a_s;
    logic        a_yv, a_yr, a_busy;

    logic [11:0] b_i;
    logic [2:0]  b_valid, b_ready, b_last;
    logic [3:0]  b_y;
    logic [1:0]  b_s;
    logic        b_yv, b_yr, b_busy;

    int errors = 0;
    int checks = 0;

    int ma_busy, ma_sel, ma_ptr;
    int mb_busy, mb_sel, mb_ptr;

    logic [5:0]  obs_a;
    logic [10:0] obs_b;
    assign obs_a = {a_s, a_y, a_yv, a_ready, a_busy};
    assign obs_b = {b_s, b_y, b_yv, b_ready, b_busy};

    mux_rr_arbiter #(.N(2), .W(1)) dut_a (
        .CLK(clk), .RST(rst), .I(a_i), .VALID(a_valid), .READY(a_ready),
        .Y(a_y), .Y_VALID(a_yv), .Y_READY(a_yr),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .LAST(a_last),
`endif
        .S(a_s), .BUSY(a_busy)
    );

    mux_rr_arbiter #(.N(3), .W(4)) dut_b (
        .CLK(clk), .RST(rst), .I(b_i), .VALID(b_valid), .READY(b_ready),
        .Y(b_y), .Y_VALID(b_yv), .Y_READY(b_yr),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .LAST(b_last),
`endif
        .S(b_s), .BUSY(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int rr(input int n, input int ptr, input logic [7:0] req);
        for (int off = 0; off < n; off++) begin
            if (req[(ptr + off) % n]) return (ptr + off) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input string name, input int n, input logic [7:0] valid,
                              input logic yready, input logic [7:0] last,
                              inout int busy, inout int sel, inout int ptr);
        logic [7:0] req;
        int k;
        if (busy == 0) begin
            k = rr(n, ptr, valid);
            if (k >= 0) begin
                busy = 1;
                sel  = k;
            end
        end else if (valid[sel] && yready) begin
            $display("xfer %s requester=%0d", name, sel);
            if (!LOCK || last[sel]) begin
                ptr = (sel + 1) % n;
                req = valid;
                req[sel] = 1'b0;
                if (req == 8'd0) req = valid;
                k = rr(n, ptr, req);
                if (k >= 0) sel = k;
                else busy = 0;
            end
        end
    endtask

    function automatic logic [5:0] exp_a();
        logic [5:0] e;
        e    = '0;
        e[5] = ma_sel[0];
        if (ma_busy != 0) begin
            e[4]   = a_i[ma_sel];
            e[3]   = a_valid[ma_sel];
            e[2:1] = a_yr ? (2'b01 << ma_sel) : 2'b00;
            e[0]   = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [10:0] exp_b();
        logic [10:0] e;
        e      = '0;
        e[10:9] = mb_sel[1:0];
        if (mb_busy != 0) begin
            e[8:5] = b_i[mb_sel*4 +: 4];
            e[4]   = b_valid[mb_sel];
            e[3:1] = b_yr ? (3'b001 << mb_sel) : 3'b000;
            e[0]   = 1'b1;
        end
        return e;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic clear_inputs();
        a_i = '0; a_valid = '0; a_yr = 1'b0; a_last = '1;
        b_i = '0; b_valid = '0; b_yr = 1'b0; b_last = '1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        ma_busy = 0; ma_sel = 0; ma_ptr = 0;
        mb_busy = 0; mb_sel = 0; mb_ptr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        a_valid = 2'b11; a_yr = 1'b1; a_i = 2'b11;
        b_valid = 3'b111; b_yr = 1'b1; b_i = 12'hFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a !== 6'b0) begin
            errors++; $display("FAIL reset_a: got %b expected %b", obs_a, 6'b0);
        end
        checks++;
        if (obs_b !== 11'b0) begin
            errors++; $display("FAIL reset_b: got %b expected %b", obs_b, 11'b0);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        a_i = 2'b10; a_valid = 2'b10; a_yr = 1'b1;
        #1;
        checks++;
        if (obs_a !== 6'b0_0_0_00_0) begin
            errors++; $display("FAIL single_idle: got %b expected %b", obs_a, 6'b0);
        end
        @(negedge clk); #1;
        checks++;
        if (obs_a !== 6'b1_1_1_10_1) begin
            errors++; $display("FAIL single_grant: got %b expected %b", obs_a, 6'b1_1_1_10_1);
        end
        // Sole requester keeps the grant after its transfer; now it goes quiet.
        @(negedge clk);
        a_valid = 2'b00;
        #1;
        checks++;
        if (obs_a !== 6'b1_1_0_10_1) begin
            errors++; $display("FAIL single_hold_novalid: got %b expected %b", obs_a, 6'b1_1_0_10_1);
        end
        @(negedge clk);
        a_valid = 2'b11;
        #1;
        checks++;
        if (obs_a !== 6'b1_1_1_10_1) begin
            errors++; $display("FAIL single_still_held: got %b expected %b", obs_a, 6'b1_1_1_10_1);
        end
        // Transfer from 1 wraps ptr to 0, so requester 0 wins next.
        @(negedge clk); #1;
        checks++;
        if (obs_a !== 6'b0_0_1_01_1) begin
            errors++; $display("FAIL single_wrap_ptr: got %b expected %b", obs_a, 6'b0_0_1_01_1);
        end
    endtask

    task automatic test_fairness();
        logic [5:0] e;
        do_reset();
        a_i = 2'b10; a_valid = 2'b11; a_yr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            e = (i % 2 == 0) ? 6'b0_0_1_01_1 : 6'b1_1_1_10_1;
            $display("fairness beat %0d S=%0d Y=%0d", i, a_s, a_y);
            checks++;
            if (obs_a !== e) begin
                errors++; $display("FAIL fairness beat %0d: got %b expected %b", i, obs_a, e);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_i = 2'b01; a_valid = 2'b11; a_yr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs_a !== 6'b0_1_1_00_1) begin
                errors++; $display("FAIL backpressure hold %0d: got %b expected %b", i, obs_a, 6'b0_1_1_00_1);
            end
        end
        @(negedge clk);
        a_yr = 1'b1;
        #1;
        checks++;
        if (obs_a !== 6'b0_1_1_01_1) begin
            errors++; $display("FAIL backpressure ready: got %b expected %b", obs_a, 6'b0_1_1_01_1);
        end
        @(negedge clk); #1;
        checks++;
        if (obs_a !== 6'b1_0_1_10_1) begin
            errors++; $display("FAIL backpressure handover: got %b expected %b", obs_a, 6'b1_0_1_10_1);
        end
    endtask

    task automatic test_wrap3();
        do_reset();
        b_i = {4'hC, 4'hB, 4'hA}; b_valid = 3'b010; b_yr = 1'b1;
        #1;
        checks++;
        if (obs_b !== 11'b0) begin
            errors++; $display("FAIL wrap3_idle: got %b expected %b", obs_b, 11'b0);
        end
        @(negedge clk);
        b_valid = 3'b011;
        #1;
        checks++;
        if (obs_b !== {2'd1, 4'hB, 1'b1, 3'b010, 1'b1}) begin
            errors++; $display("FAIL wrap3_grant1: got %b expected %b", obs_b, {2'd1, 4'hB, 1'b1, 3'b010, 1'b1});
        end
        // ptr is now 2; requester 2 idle, so the scan wraps to 0.
        @(negedge clk); #1;
        checks++;
        if (obs_b !== {2'd0, 4'hA, 1'b1, 3'b001, 1'b1}) begin
            errors++; $display("FAIL wrap3_to0: got %b expected %b", obs_b, {2'd0, 4'hA, 1'b1, 3'b001, 1'b1});
        end
        @(negedge clk); #1;
        checks++;
        if (obs_b !== {2'd1, 4'hB, 1'b1, 3'b010, 1'b1}) begin
            errors++; $display("FAIL wrap3_to1: got %b expected %b", obs_b, {2'd1, 4'hB, 1'b1, 3'b010, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_i = 2'b11; a_valid = 2'b11; a_yr = 1'b0;
        b_i = 12'h123; b_valid = 3'b100; b_yr = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre: got busy %b%b expected 11", a_busy, b_busy);
        end
        @(posedge clk);
        a_yr = 1'b1; b_yr = 1'b1;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (obs_a !== 6'b0 || obs_b !== 11'b0) begin
            errors++; $display("FAIL reset_mid_async: got %b %b expected all zero", obs_a, obs_b);
        end
        @(negedge clk);
        rst = 1'b0;
        a_valid = 2'b00; b_valid = 3'b000;
        @(negedge clk); #1;
        checks++;
        if (obs_a !== 6'b0 || obs_b !== 11'b0) begin
            errors++; $display("FAIL reset_mid_after: got %b %b expected all zero", obs_a, obs_b);
        end
    endtask

`ifdef MUX_RR_ARBITER_LOCK_EN
    task automatic test_lock();
        do_reset();
        a_i = 2'b10; a_valid = 2'b11; a_yr = 1'b1; a_last = 2'b00;
        for (int beat = 0; beat < 3; beat++) begin
            @(negedge clk);
            a_last = (beat == 2) ? 2'b01 : 2'b00;
            #1;
            checks++;
            if (obs_a !== 6'b0_0_1_01_1) begin
                errors++; $display("FAIL lock beat %0d: got %b expected %b", beat, obs_a, 6'b0_0_1_01_1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (obs_a !== 6'b1_1_1_10_1) begin
            errors++; $display("FAIL lock_release: got %b expected %b", obs_a, 6'b1_1_1_10_1);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            a_valid = 2'($urandom);
            a_i     = 2'($urandom);
            a_yr    = ($urandom_range(0, 3) != 0);
            a_last  = LOCK ? 2'($urandom) : 2'b11;
            b_valid = 3'($urandom);
            b_i     = 12'($urandom);
            b_yr    = ($urandom_range(0, 3) != 0);
            b_last  = LOCK ? 3'($urandom) : 3'b111;
            #1;
            checks++;
            if (obs_a !== exp_a()) begin
                errors++; $display("FAIL random_a cycle %0d: got %b expected %b", c, obs_a, exp_a());
            end
            checks++;
            if (obs_b !== exp_b()) begin
                errors++; $display("FAIL random_b cycle %0d: got %b expected %b", c, obs_b, exp_b());
            end
            model_step("a", 2, {6'b0, a_valid}, a_yr, {6'b0, a_last}, ma_busy, ma_sel, ma_ptr);
            model_step("b", 3, {5'b0, b_valid}, b_yr, {5'b0, b_last}, mb_busy, mb_sel, mb_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap3();
        test_reset_mid();
`ifdef MUX_RR_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
